bp_update_queue: RTL and testbench
==================================

Name: bp_update_queue

Overview:
- Buffers branch-resolution events from both execute pipes and issues them one per cycle to the fetch1 predictor update ports (BTB write, PHT counter update, wasnt-branch fix).
- Sits between the two execute-stage branch units and fetch1.
- Resolves the case where both pipes resolve in the same cycle, because the predictor has a single update port.
- Preserves program order: pipe 0 is older than pipe 1 in the same cycle.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥ 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clock_i  in  1  clock.
- reset_ni  in  1  reset; asynchronous, active-low.
- res_valid_0_i  in  1  pipe 0 has a resolved control-flow event.
- res_pc_0_i  in  32  PC of the pipe 0 instruction.
- res_tgt_0_i  in  32  resolved target of the pipe 0 instruction.
- res_taken_0_i  in  1  pipe 0 branch taken.
- res_is_br_0_i  in  1  pipe 0 instruction really is a branch; 0 means predicted taken but not a branch.
- res_valid_1_i, res_pc_1_i, res_tgt_1_i, res_taken_1_i, res_is_br_1_i  in  1/32/32/1/1  same fields for pipe 1.
- pc_we_i  in  1  fetch1 PC write enable; the predictor commits an update only on these cycles.
- ready_o  out  1  queue can accept two events this cycle.
- update_pc_o  out  32  to fetch1 update_pc_i.
- update_tgt_o  out  32  to fetch1 update_tgt_i.
- last_br_o  out  1  to fetch1 last_br_i.
- update_pht_o  out  1  to fetch1 update_pht_i.
- update_btb_o  out  1  to fetch1 update_btb_i.
- wasnt_branch_o  out  1  to fetch1 wasnt_branch_i.
- wasnt_br_pc_o  out  32  to fetch1 wasnt_br_pc_i.
- occupancy_o  out  $clog2(DEPTH)+1  current entry count.
- drop_cnt_o  out  CNT_W  number of events discarded.

Behaviour:

Entry and reset
- Entry fields: {pc[31:0], tgt[31:0], kind[1:0]}.
- kind values: KIND_TAKEN = taken && is_br; KIND_NTAKEN = !taken && is_br; KIND_NOTBR = !is_br (taken ignored).
- On reset_ni low, immediately clear rd_ptr, wr_ptr, count and drop_cnt to 0. Storage contents are don't-care.
- While reset is asserted and after release, all update outputs are 0 and ready_o = 1.

Ready and enqueue
- ready_o = (count <= DEPTH-2), computed from the registered count only. There is no combinational path from valid inputs or pc_we_i.
- Enqueue on the rising edge when ready_o = 1:
  - Both valid: pipe 0 is written at wr_ptr, pipe 1 at wr_ptr+1, and wr_ptr += 2.
  - Only one valid: that event is written at wr_ptr, and wr_ptr += 1.
- If ready_o = 0, every valid input that cycle is dropped. drop_cnt increments by the number dropped (1 or 2) and saturates at all-ones.

Head and outputs
- head valid = (count != 0). Outputs decode the head entry combinationally from registered storage.
- Empty: all strobes are 0, and update_pc_o, update_tgt_o and wasnt_br_pc_o are 0.
- KIND_TAKEN: update_pht_o=1, update_btb_o=1, last_br_o=1, update_pc_o=pc, update_tgt_o=tgt, wasnt_branch_o=0.
- KIND_NTAKEN: update_pht_o=1, update_btb_o=0, last_br_o=0, update_pc_o=pc, wasnt_branch_o=0.
- KIND_NOTBR: wasnt_branch_o=1, wasnt_br_pc_o=pc, update_pht_o=0, update_btb_o=0, last_br_o=0, update_pc_o=pc.

Dequeue and count
- Dequeue on the rising edge when head valid && pc_we_i: rd_ptr += 1.
- An entry that is held while pc_we_i = 0 (stall) stays at the head with its outputs stable.
- count_next = count + pushes - pop. A simultaneous push of 2 and a pop at count = DEPTH-2 gives DEPTH-1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

Latency and invariants
- An event enqueued at edge N on an empty queue is visible on the outputs in the cycle after edge N. There is no bypass.
- No entry is ever reordered, duplicated or overwritten.
- count never exceeds DEPTH.
- Mispredict recovery in fetch1 does not flush this queue: updates are architectural.

Decomposition:
- Shared defines file: KIND_TAKEN=2'd0, KIND_NTAKEN=2'd1, KIND_NOTBR=2'd2, and the entry width macro.
- One sub-module, bpq_fifo_2w1r: a 2-write, 1-read circular buffer holding storage, pointers and count.
- The top level holds kind encoding, output decode, ready logic and the drop counter.

Test Plan:
- Reset/empty: assert reset_ni=0 mid-run with count=3 -> count=0 and all strobes 0 in the same cycle. After release, ready_o=1 and occupancy_o=0.
- Single taken: pipe 0 pc=0x100, tgt=0x40, taken=1, is_br=1, pc_we_i=1 -> next cycle update_btb_o=1, update_pht_o=1, last_br_o=1, update_pc_o=0x100, update_tgt_o=0x40. Queue is empty the following cycle.
- Dual same cycle: pipe 0 pc=0x200 not-taken and pipe 1 pc=0x208 not-branch -> cycle 1 shows NTAKEN for 0x200 (last_br_o=0); cycle 2 shows wasnt_branch_o=1, wasnt_br_pc_o=0x208.
- Stall hold: enqueue taken 0x300 with pc_we_i=0 for 5 cycles -> outputs constant for 5 cycles. Pop occurs on the first cycle with pc_we_i=1.
- Full/drop: DEPTH=4, pc_we_i=0, two dual pushes -> count=4, ready_o=0. A third dual push -> drop_cnt_o=2 and count stays 4. Then drain 4 pops in order.
- Wrap: 10 alternating single/dual pushes with continuous pc_we_i=1 -> outputs match a reference FIFO model in exact order across pointer wrap, and count never exceeds 4.

Source files
------------

// File: rtl/bp_update_queue_pkg.sv
// Shared types for the branch-predictor update queue: event kinds and the
// stored entry layout.
package bp_update_queue_pkg;

    typedef enum logic [1:0] {
        KIND_TAKEN  = 2'd0,
        KIND_NTAKEN = 2'd1,
        KIND_NOTBR  = 2'd2
    } kind_e;

    localparam int unsigned ENTRY_W = 66;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        kind_e       kind;
    } entry_t;

    // A non-branch that was predicted taken is flagged regardless of taken.
    function automatic kind_e encode_kind(input logic taken, input logic is_br);
        if (!is_br)
            return KIND_NOTBR;
        else if (taken)
            return KIND_TAKEN;
        else
            return KIND_NTAKEN;
    endfunction

endpackage

// File: rtl/bp_update_queue_fifo_2w1r.sv
// Two-write, one-read circular buffer. Writes of push_cnt entries go to
// consecutive slots starting at wr_ptr; data_a is always the older entry.
module bpq_fifo_2w1r
    import bp_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               push_cnt,
    input  entry_t                   data_a,
    input  entry_t                   data_b,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_b;
    logic             do_pop;

    assign wr_ptr_b = wr_ptr + PTR_W'(1);
    assign do_pop   = pop && (count != '0);
    assign head     = mem[rd_ptr];

    // Storage is left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0)
            mem[wr_ptr] <= data_a;
        if (push_cnt == 2'd2)
            mem[wr_ptr_b] <= data_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/bp_update_queue.sv
// Serialises branch-resolution events from two execute pipes onto the single
// fetch1 predictor update port, in program order, with a saturating drop count.
module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     res_valid_0_i,
    input  logic [31:0]              res_pc_0_i,
    input  logic [31:0]              res_tgt_0_i,
    input  logic                     res_taken_0_i,
    input  logic                     res_is_br_0_i,
    input  logic                     res_valid_1_i,
    input  logic [31:0]              res_pc_1_i,
    input  logic [31:0]              res_tgt_1_i,
    input  logic                     res_taken_1_i,
    input  logic                     res_is_br_1_i,
    input  logic                     pc_we_i,
    output logic                     ready_o,
    output logic [31:0]              update_pc_o,
    output logic [31:0]              update_tgt_o,
    output logic                     last_br_o,
    output logic                     update_pht_o,
    output logic                     update_btb_o,
    output logic                     wasnt_branch_o,
    output logic [31:0]              wasnt_br_pc_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    entry_t           ev_0;
    entry_t           ev_1;
    entry_t           head;
    logic [OCC_W-1:0] count;
    logic [1:0]       push_cnt;
    logic [1:0]       drop_n;
    logic [CNT_W:0]   drop_sum;

    assign ev_0 = '{pc: res_pc_0_i, tgt: res_tgt_0_i,
                    kind: encode_kind(res_taken_0_i, res_is_br_0_i)};
    assign ev_1 = '{pc: res_pc_1_i, tgt: res_tgt_1_i,
                    kind: encode_kind(res_taken_1_i, res_is_br_1_i)};

    assign ready_o     = (count <= OCC_W'(DEPTH - 2));
    assign occupancy_o = count;

    always_comb begin
        push_cnt = 2'd0;
        drop_n   = 2'd0;
        if (ready_o)
            push_cnt = {1'b0, res_valid_0_i} + {1'b0, res_valid_1_i};
        else
            drop_n   = {1'b0, res_valid_0_i} + {1'b0, res_valid_1_i};
    end

    // A lone pipe-1 event still lands at wr_ptr, so steer it onto port A.
    bpq_fifo_2w1r #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clock_i),
        .rst_n    (reset_ni),
        .push_cnt (push_cnt),
        .data_a   (res_valid_0_i ? ev_0 : ev_1),
        .data_b   (ev_1),
        .pop      (pc_we_i),
        .head     (head),
        .count    (count)
    );

    assign drop_sum = {1'b0, drop_cnt_o} + (CNT_W + 1)'(drop_n);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)
            drop_cnt_o <= '0;
        else if (drop_sum[CNT_W])
            drop_cnt_o <= '1;
        else
            drop_cnt_o <= drop_sum[CNT_W-1:0];
    end

    always_comb begin
        update_pc_o    = '0;
        update_tgt_o   = '0;
        last_br_o      = 1'b0;
        update_pht_o   = 1'b0;
        update_btb_o   = 1'b0;
        wasnt_branch_o = 1'b0;
        wasnt_br_pc_o  = '0;
        if (count != '0) begin
            unique case (head.kind)
                KIND_TAKEN: begin
                    update_pht_o = 1'b1;
                    update_btb_o = 1'b1;
                    last_br_o    = 1'b1;
                    update_pc_o  = head.pc;
                    update_tgt_o = head.tgt;
                end
                KIND_NTAKEN: begin
                    update_pht_o = 1'b1;
                    update_pc_o  = head.pc;
                end
                KIND_NOTBR: begin
                    wasnt_branch_o = 1'b1;
                    wasnt_br_pc_o  = head.pc;
                    update_pc_o    = head.pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed vector table, hand
// sequences for stall/full/reset, and random traffic against a queue model.
module tb_bp_update_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b1;
    logic        res_valid_0_i = 1'b0, res_taken_0_i = 1'b0, res_is_br_0_i = 1'b0;
    logic [31:0] res_pc_0_i = '0, res_tgt_0_i = '0;
    logic        res_valid_1_i = 1'b0, res_taken_1_i = 1'b0, res_is_br_1_i = 1'b0;
    logic [31:0] res_pc_1_i = '0, res_tgt_1_i = '0;
    logic        pc_we_i = 1'b0;
    logic        ready_o, last_br_o, update_pht_o, update_btb_o, wasnt_branch_o;
    logic [31:0] update_pc_o, update_tgt_o, wasnt_br_pc_o;
    logic [2:0]  occupancy_o;
    logic [15:0] drop_cnt_o;

    bp_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .res_valid_0_i(res_valid_0_i), .res_pc_0_i(res_pc_0_i), .res_tgt_0_i(res_tgt_0_i),
        .res_taken_0_i(res_taken_0_i), .res_is_br_0_i(res_is_br_0_i),
        .res_valid_1_i(res_valid_1_i), .res_pc_1_i(res_pc_1_i), .res_tgt_1_i(res_tgt_1_i),
        .res_taken_1_i(res_taken_1_i), .res_is_br_1_i(res_is_br_1_i),
        .pc_we_i(pc_we_i), .ready_o(ready_o),
        .update_pc_o(update_pc_o), .update_tgt_o(update_tgt_o), .last_br_o(last_br_o),
        .update_pht_o(update_pht_o), .update_btb_o(update_btb_o),
        .wasnt_branch_o(wasnt_branch_o), .wasnt_br_pc_o(wasnt_br_pc_o),
        .occupancy_o(occupancy_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        is_br;
    } ev_t;

    typedef struct {
        ev_t         e0;
        ev_t         e1;
        logic        we;
        logic [31:0] x_pc;
        logic [31:0] x_tgt;
        logic [31:0] x_wbpc;
        logic [3:0]  x_strb;  // {pht, btb, last_br, wasnt_branch}
        int          x_occ;
    } vec_t;

    int n_vec = 0;
    int n_miss = 0;
    ev_t q[$];
    int drop_m = 0;

    function automatic ev_t mkev(logic v, logic [31:0] pc, logic [31:0] tgt,
                                 logic taken, logic is_br);
        ev_t e;
        e.v = v; e.pc = pc; e.tgt = tgt; e.taken = taken; e.is_br = is_br;
        return e;
    endfunction

    function automatic ev_t rnd_ev(logic v);
        return mkev(v, $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom), 1'($urandom));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {update_pht_o, update_btb_o, last_br_o, wasnt_branch_o};
    endfunction

    // Expected outputs derived from the head of the reference queue.
    task automatic check_model(input string tag);
        ev_t h;
        check({tag, ".occ"}, 32'(occupancy_o), 32'(q.size()));
        check({tag, ".ready"}, 32'(ready_o), 32'(q.size() <= DEPTH - 2));
        check({tag, ".drop"}, 32'(drop_cnt_o), 32'(drop_m));
        check({tag, ".occ_max"}, 32'(occupancy_o <= DEPTH), 32'd1);
        if (q.size() == 0) begin
            check({tag, ".strb"}, 32'(strobes()), 32'd0);
            check({tag, ".pc"}, update_pc_o, 32'd0);
            check({tag, ".tgt"}, update_tgt_o, 32'd0);
            check({tag, ".wbpc"}, wasnt_br_pc_o, 32'd0);
        end else begin
            h = q[0];
            check({tag, ".strb"}, 32'(strobes()),
                  32'({h.is_br, h.is_br && h.taken, h.is_br && h.taken, !h.is_br}));
            check({tag, ".pc"}, update_pc_o, h.pc);
            if (h.is_br && h.taken)
                check({tag, ".tgt"}, update_tgt_o, h.tgt);
            check({tag, ".wbpc"}, wasnt_br_pc_o, h.is_br ? 32'd0 : h.pc);
        end
    endtask

    task automatic model_step(input ev_t e0, input ev_t e1, input logic we);
        bit rdy;
        rdy = (q.size() <= DEPTH - 2);
        if (q.size() != 0 && we)
            q.delete(0);
        if (rdy) begin
            if (e0.v) q.push_back(e0);
            if (e1.v) q.push_back(e1);
        end else begin
            drop_m = drop_m + int'(e0.v) + int'(e1.v);
            if (drop_m > DROP_MAX) drop_m = DROP_MAX;
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next one.
    task automatic apply(input ev_t e0, input ev_t e1, input logic we);
        res_valid_0_i = e0.v; res_pc_0_i = e0.pc; res_tgt_0_i = e0.tgt;
        res_taken_0_i = e0.taken; res_is_br_0_i = e0.is_br;
        res_valid_1_i = e1.v; res_pc_1_i = e1.pc; res_tgt_1_i = e1.tgt;
        res_taken_1_i = e1.taken; res_is_br_1_i = e1.is_br;
        pc_we_i = we;
        @(posedge clock_i);
        model_step(e0, e1, we);
        @(negedge clock_i);
    endtask

    task automatic do_reset(input string tag);
        ev_t none;
        none = mkev(0, 0, 0, 0, 0);
        res_valid_0_i = 1'b0; res_valid_1_i = 1'b0; pc_we_i = 1'b0;
        reset_ni = 1'b0;
        #1;
        check({tag, ".rst_occ"}, 32'(occupancy_o), 32'd0);
        check({tag, ".rst_strb"}, 32'(strobes()), 32'd0);
        check({tag, ".rst_pc"}, update_pc_o, 32'd0);
        check({tag, ".rst_ready"}, 32'(ready_o), 32'd1);
        check({tag, ".rst_drop"}, 32'(drop_cnt_o), 32'd0);
        q.delete();
        drop_m = 0;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_ni = 1'b1;
        @(negedge clock_i);
        check_model({tag, ".post_rst"});
        none.v = 1'b0;
    endtask

    vec_t tbl[7];
    ev_t none, e0, e1;

    initial begin
        none = mkev(0, 0, 0, 0, 0);
        tbl[0] = '{mkev(1, 32'h100, 32'h40, 1, 1), none, 1'b1,
                   32'h100, 32'h40, 32'h0, 4'b1110, 1};
        tbl[1] = '{none, none, 1'b1, 32'h0, 32'h0, 32'h0, 4'b0000, 0};
        tbl[2] = '{mkev(1, 32'h200, 32'h0, 0, 1), mkev(1, 32'h208, 32'h0, 1, 0), 1'b1,
                   32'h200, 32'h0, 32'h0, 4'b1000, 2};
        tbl[3] = '{none, none, 1'b1, 32'h208, 32'h0, 32'h208, 4'b0001, 1};
        tbl[4] = '{none, none, 1'b1, 32'h0, 32'h0, 32'h0, 4'b0000, 0};
        tbl[5] = '{none, mkev(1, 32'h500, 32'h600, 1, 1), 1'b1,
                   32'h500, 32'h600, 32'h0, 4'b1110, 1};
        tbl[6] = '{none, none, 1'b1, 32'h0, 32'h0, 32'h0, 4'b0000, 0};

        #2;
        @(negedge clock_i);
        do_reset("init");

        foreach (tbl[i]) begin
            apply(tbl[i].e0, tbl[i].e1, tbl[i].we);
            check($sformatf("tbl%0d.strb", i), 32'(strobes()), 32'(tbl[i].x_strb));
            check($sformatf("tbl%0d.pc", i), update_pc_o, tbl[i].x_pc);
            if (tbl[i].x_strb[2])
                check($sformatf("tbl%0d.tgt", i), update_tgt_o, tbl[i].x_tgt);
            check($sformatf("tbl%0d.wbpc", i), wasnt_br_pc_o, tbl[i].x_wbpc);
            check($sformatf("tbl%0d.occ", i), 32'(occupancy_o), 32'(tbl[i].x_occ));
            check_model($sformatf("tbl%0d", i));
        end

        // Stall: a head entry held with pc_we low stays put, pops on first pc_we.
        apply(mkev(1, 32'h300, 32'h380, 1, 1), none, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(none, none, 1'b0);
            check("stall.pc", update_pc_o, 32'h300);
            check("stall.tgt", update_tgt_o, 32'h380);
            check("stall.strb", 32'(strobes()), 32'b1110);
            check_model("stall");
        end
        apply(none, none, 1'b1);
        check("stall.pop_occ", 32'(occupancy_o), 32'd0);
        check_model("stall_pop");

        // Fill to DEPTH, then a dual push is dropped in full.
        apply(mkev(1, 32'h1000, 32'h1, 1, 1), mkev(1, 32'h1004, 32'h2, 0, 1), 1'b0);
        apply(mkev(1, 32'h1008, 32'h3, 1, 0), mkev(1, 32'h100C, 32'h4, 1, 1), 1'b0);
        check("full.occ", 32'(occupancy_o), 32'd4);
        check("full.ready", 32'(ready_o), 32'd0);
        apply(mkev(1, 32'h2000, 32'h5, 1, 1), mkev(1, 32'h2004, 32'h6, 1, 1), 1'b0);
        check("full.drop", 32'(drop_cnt_o), 32'd2);
        check("full.occ_hold", 32'(occupancy_o), 32'd4);
        check_model("full");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.pc", i), update_pc_o, 32'h1000 + 32'(4 * i));
            apply(none, none, 1'b1);
            check_model($sformatf("drain%0d", i));
        end

        // Dual push plus pop at DEPTH-2 lands on DEPTH-1; next push is dropped.
        apply(mkev(1, 32'h3000, 0, 0, 1), mkev(1, 32'h3004, 0, 0, 1), 1'b0);
        apply(mkev(1, 32'h3008, 0, 0, 0), mkev(1, 32'h300C, 0, 1, 1), 1'b1);
        check("edge.occ3", 32'(occupancy_o), 32'd3);
        check("edge.ready", 32'(ready_o), 32'd0);
        apply(mkev(1, 32'h3010, 0, 1, 1), none, 1'b0);
        check("edge.drop3", 32'(drop_cnt_o), 32'd3);
        check_model("edge");

        // Asynchronous reset mid-run with three entries held.
        do_reset("mid");

        // Alternating single/dual pushes with continuous dequeue across wrap.
        for (int i = 0; i < 10; i++) begin
            e0 = rnd_ev(1);
            e1 = rnd_ev(i % 2 == 1);
            apply(e0, e1, 1'b1);
            check_model($sformatf("wrap%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            apply(none, none, 1'b1);
            check_model("wrap_drain");
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            e0 = rnd_ev(($urandom % 3) != 0);
            e1 = rnd_ev(($urandom % 2) != 0);
            apply(e0, e1, ($urandom % 4) != 0);
            check_model("rand");
        end

        // Drop counter saturation.
        do_reset("sat");
        apply(rnd_ev(1), rnd_ev(1), 1'b0);
        apply(rnd_ev(1), rnd_ev(1), 1'b0);
        for (int i = 0; i < 32768; i++)
            apply(rnd_ev(1), rnd_ev(1), 1'b0);
        check("sat.drop", 32'(drop_cnt_o), 32'(DROP_MAX));
        apply(rnd_ev(1), none, 1'b0);
        check("sat.hold", 32'(drop_cnt_o), 32'(DROP_MAX));
        check_model("sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
